// File: rtl/decode_seq.sv
// Sequencing instruction decoder: EXEC1/EXEC2 phasing, multi-cycle MUL, stack SP, HALT.
// Optional STACK_GUARD_EN: stack over/underflow goes to a sticky FAULT state.
module decode_seq #(
  parameter int MUL_LAT     = 1,
  parameter int STACK_DEPTH = 16,
  parameter int SPW         = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [15:0]    instr,
  input  logic           COND_result,
  input  logic           run,
  output logic [7:0]     R_en,
  output logic           R0_count,
  output logic [2:0]     s1,
  output logic [2:0]     s2,
  output logic [2:0]     s3,
  output logic           s4,
  output logic           RAMd_wren,
  output logic           RAMd_en,
  output logic           RAMi_en,
  output logic           ALU_en,
  output logic           stack_en,
  output logic           stack_rw,
`ifdef STACK_GUARD_EN
  output logic [SPW:0]   sp,
`else
  output logic [SPW-1:0] sp,
`endif
  output logic           exec1,
  output logic           exec2,
  output logic           halted,
  output logic           fault
);

  typedef enum logic [1:0] {
    S_EXEC1, S_EXEC2, S_HALT, S_FAULT
  } state_t;

`ifdef STACK_GUARD_EN
  // one extra bit so a completely full stack is representable
  localparam int SPL = SPW + 1;
`else
  localparam int SPL = SPW;
`endif
  localparam logic [SPL-1:0] SP_ONE = SPL'(1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [SPL-1:0] sp_q, sp_d;

  logic       ls, is_st, is_ld;
  logic [5:0] op;
  logic [2:0] rls, rd, rs1, rs2;
  logic       is_ujmp, is_jmp, is_mul;
  logic       is_psh, is_pop, is_nop, is_stp, is_alu;
  logic       stk_bad, last;
  logic [2:0] sel1, sel2, sel3;

  assign ls    = instr[15];
  assign is_st = ls & instr[14];
  assign is_ld = ls & ~instr[14];
  assign rls   = instr[13:11];
  assign op    = instr[14:9];
  assign rd    = instr[8:6];
  assign rs1   = instr[5:3];
  assign rs2   = instr[2:0];

  assign is_ujmp = ~ls & (op[5:2] == 4'b0000);
  assign is_jmp  = ~ls & ((op[5:2] == 4'b0001) |
                          (op[5:2] == 4'b0010));
  assign is_mul  = ~ls & ((op == 6'b011100) |
                          (op == 6'b011101) |
                          (op == 6'b011110));
  assign is_psh  = ~ls & (op == 6'b101000);
  assign is_pop  = ~ls & (op == 6'b101001);
  assign is_nop  = ~ls & (op == 6'b111110);
  assign is_stp  = ~ls & (op == 6'b111111);
  assign is_alu  = ~ls & ~(is_ujmp | is_jmp | is_mul |
                           is_psh | is_pop | is_nop | is_stp);

`ifdef STACK_GUARD_EN
  localparam logic [SPL-1:0] SP_FULL = SPL'(STACK_DEPTH);
  assign stk_bad = (is_psh & (sp_q == SP_FULL)) |
                   (is_pop & (sp_q == '0));
`else
  assign stk_bad = 1'b0;
`endif

  // instr is held while RAMi_en=0, so EXEC2 can re-decode it
  assign last = is_mul ? (cnt_q == 4'(MUL_LAT - 1)) : 1'b1;

  assign sel1 = (is_alu | is_mul | is_psh) ? rs1 :
                (is_st ? rls : 3'd0);
  assign sel2 = (is_alu | is_mul) ? rs2 : 3'd0;
  assign sel3 = (is_alu | is_mul) ? rd  : 3'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_EXEC1;
      cnt_q   <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    unique case (state_q)
      S_EXEC1: begin
        cnt_d = '0;
        if (stk_bad) begin
          state_d = S_FAULT;
        end else if (is_stp) begin
          state_d = S_HALT;
          sp_d    = '0;
        end else begin
          if (is_psh) sp_d = sp_q + SP_ONE;
          if (is_pop) sp_d = sp_q - SP_ONE;
          if (is_ld | is_pop | is_mul) state_d = S_EXEC2;
        end
      end
      S_EXEC2: begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          state_d = S_EXEC1;
          cnt_d   = '0;
        end
      end
      S_HALT: begin
        if (run) state_d = S_EXEC1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_EXEC1;
    endcase
  end

  always_comb begin
    R_en      = '0;
    R0_count  = 1'b0;
    s1        = '0;
    s2        = '0;
    s3        = '0;
    s4        = 1'b0;
    RAMd_wren = 1'b0;
    RAMd_en   = 1'b0;
    RAMi_en   = 1'b0;
    ALU_en    = 1'b0;
    stack_en  = 1'b0;
    stack_rw  = 1'b0;
    exec1     = 1'b0;
    exec2     = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    if (RST) begin
      exec1 = 1'b1;
    end else begin
      unique case (state_q)
        S_EXEC1: begin
          exec1    = 1'b1;
          R0_count = ~(is_ujmp | is_jmp | is_stp | stk_bad);
          if (is_alu) R_en[rd] = 1'b1;
          if (is_ujmp | (is_jmp & COND_result)) R_en[0] = 1'b1;
          s1        = sel1;
          s2        = sel2;
          s3        = sel3;
          s4        = ~ls;
          RAMd_en   = ls;
          RAMd_wren = is_st;
          ALU_en    = ls;
          RAMi_en   = ~(is_ld | is_pop | is_mul | is_stp | stk_bad);
          stack_en  = (is_psh | is_pop) & ~stk_bad;
          stack_rw  = is_pop & ~stk_bad;
        end
        S_EXEC2: begin
          exec2 = 1'b1;
          s1    = sel1;
          s2    = sel2;
          s3    = sel3;
          s4    = ~ls;
          if (last) begin
            R_en[is_ld ? rls : rd] = 1'b1;
            RAMi_en = 1'b1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        S_FAULT: begin
          halted = 1'b1;
`ifdef STACK_GUARD_EN
          fault  = 1'b1;
`endif
        end
        default: exec1 = 1'b0;
      endcase
    end
  end

  assign sp = sp_q;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: vector table, directed multi-cycle sequences,
// and random instructions checked against an abstract phase/stack model.
module tb_decode_seq;
  localparam int ML = 3;
  localparam int D  = 16;
  localparam int W  = 4;
`ifdef STACK_GUARD_EN
  localparam int SPB = W + 1;
`else
  localparam int SPB = W;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [15:0]    instr = 16'h7C00;
  logic           COND_result = 1'b0;
  logic           run = 1'b0;
  logic [7:0]     R_en;
  logic           R0_count;
  logic [2:0]     s1, s2, s3;
  logic           s4, RAMd_wren, RAMd_en, RAMi_en, ALU_en;
  logic           stack_en, stack_rw;
  logic [SPB-1:0] sp;
  logic           exec1, exec2, halted, fault;

  decode_seq #(.MUL_LAT(ML), .STACK_DEPTH(D), .SPW(W)) dut (
    .CLK(CLK), .RST(RST), .instr(instr),
    .COND_result(COND_result), .run(run),
    .R_en(R_en), .R0_count(R0_count),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .RAMd_wren(RAMd_wren), .RAMd_en(RAMd_en),
    .RAMi_en(RAMi_en), .ALU_en(ALU_en),
    .stack_en(stack_en), .stack_rw(stack_rw),
    .sp(sp), .exec1(exec1), .exec2(exec2),
    .halted(halted), .fault(fault)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    bit ls, st, ld, uj, jp, mu, ps, po, np, hl, al;
  } cls_t;

  typedef struct packed {
    logic [7:0] r_en;
    logic       r0;
    logic [9:0] sel;
    logic [3:0] mem;
    logic [1:0] stk;
    logic [3:0] st;
  } out_t;

  // model: phase 0 ready, 1 busy (m_rem cycles left), 2 halt, 3 fault
  int m_ph  = 0;
  int m_rem = 0;
  int m_sp  = 0;

  function automatic cls_t classify(input logic [15:0] i);
    cls_t k;
    int op;
    op   = int'(i[14:9]);
    k    = '0;
    k.ls = i[15];
    k.st = i[15] && i[14];
    k.ld = i[15] && !i[14];
    if (!i[15]) begin
      k.uj = op < 4;
      k.jp = op >= 4 && op < 12;
      k.mu = op >= 28 && op <= 30;
      k.ps = op == 40;
      k.po = op == 41;
      k.np = op == 62;
      k.hl = op == 63;
      k.al = !(k.uj || k.jp || k.mu || k.ps || k.po || k.np || k.hl);
    end
    return k;
  endfunction

  function automatic bit gbad(input cls_t k);
`ifdef STACK_GUARD_EN
    return (k.ps && m_sp == D) || (k.po && m_sp == 0);
`else
    return (k.ps && 1'b0);
`endif
  endfunction

  function automatic out_t mexp(input logic [15:0] i, input logic c);
    out_t o;
    cls_t k;
    bit   g;
    logic [2:0] a, b, e;
    o = '0;
    k = classify(i);
    g = gbad(k);
    case (m_ph)
      0: begin
        o.st = 4'b1000;
        if (k.al) o.r_en = 8'd1 << i[8:6];
        if (k.uj || (k.jp && c)) o.r_en = 8'd1;
        o.r0 = !(k.uj || k.jp || k.hl || g);
        a = (k.al || k.mu || k.ps) ? i[5:3] : (k.st ? i[13:11] : 3'd0);
        b = (k.al || k.mu) ? i[2:0] : 3'd0;
        e = (k.al || k.mu) ? i[8:6] : 3'd0;
        o.sel = {a, b, e, !k.ls};
        o.mem = {k.st, k.ls, !(k.ld || k.po || k.mu || k.hl || g), k.ls};
        o.stk = {(k.ps || k.po) && !g, k.po && !g};
      end
      1: begin
        o.st = 4'b0100;
        if (m_rem == 1) begin
          o.r_en = 8'd1 << (k.ld ? i[13:11] : i[8:6]);
          o.mem  = 4'b0010;
        end
      end
      2: o.st = 4'b0010;
      default: o.st = 4'b0011;
    endcase
    return o;
  endfunction

  task automatic mstep(input logic [15:0] i, input logic r);
    cls_t k;
    k = classify(i);
    case (m_ph)
      0: begin
        if (gbad(k)) m_ph = 3;
        else if (k.hl) begin
          m_ph = 2;
          m_sp = 0;
        end else begin
          if (k.ps) m_sp = (m_sp + 1) % (1 << SPB);
          if (k.po) m_sp = (m_sp + (1 << SPB) - 1) % (1 << SPB);
          if (k.ld || k.po) begin
            m_ph = 1; m_rem = 1;
          end else if (k.mu) begin
            m_ph = 1; m_rem = ML;
          end
        end
      end
      1: if (m_rem == 1) m_ph = 0; else m_rem--;
      2: if (r) m_ph = 0;
      default: m_ph = 3;
    endcase
  endtask

  task automatic cmp_all(input logic [15:0] i, input logic c,
                         input logic rs);
    out_t o;
    if (rs) begin
      o = '0;
      o.st = 4'b1000;
    end else o = mexp(i, c);
    chk("R_en", 16'(R_en), 16'(o.r_en));
    chk("R0_count", 16'(R0_count), 16'(o.r0));
    if (rs || m_ph == 0)
      chk("sel", 16'({s1, s2, s3, s4}), 16'(o.sel));
    chk("mem", 16'({RAMd_wren, RAMd_en, RAMi_en, ALU_en}), 16'(o.mem));
    chk("stack", 16'({stack_en, stack_rw}), 16'(o.stk));
    chk("sp", 16'(sp), 16'(m_sp));
    chk("state", 16'({exec1, exec2, halted, fault}), 16'(o.st));
  endtask

  task automatic drive(input logic [15:0] i, input logic c,
                       input logic r, input logic rs);
    @(negedge CLK);
    RST = rs; instr = i; COND_result = c; run = r;
    if (rs) begin
      m_ph = 0; m_rem = 0; m_sp = 0;
    end
    #1;
    cmp_all(i, c, rs);
    if (!rs) mstep(i, r);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] x;
    x = 16'($urandom);
    case ($urandom_range(0, 15))
      0, 1: x[15] = 1'b1;
      2, 3: x[15:9] = 7'(28 + $urandom_range(0, 2));
      4: x[15:9] = 7'd40;
      5: x[15:9] = 7'd41;
      6: x[15:9] = 7'd63;
      7: x[15:9] = 7'd62;
      8, 9: x[15:13] = 3'b000;
      default: x[15] = 1'b0;
    endcase
    return x;
  endfunction

  typedef struct {
    logic [15:0] ins;
    logic        cond;
    logic [7:0]  r_en;
    logic        r0;
    logic [2:0]  a, b, e;
    logic        s4, ramd, wren, rami, stk;
  } vec_t;

  vec_t vt[10];
  logic [15:0] cur;

  initial begin
    vt[0] = '{16'h20CA, 0, 8'h08, 1, 1, 2, 3, 1, 0, 0, 1, 0};
    vt[1] = '{16'h01C5, 0, 8'h01, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[2] = '{16'h0800, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[3] = '{16'h0800, 1, 8'h01, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[4] = '{16'h17FF, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[5] = '{16'hD005, 0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 1, 0};
    vt[6] = '{16'h7C00, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[7] = '{16'h3FF5, 0, 8'h80, 1, 6, 5, 7, 1, 0, 0, 1, 0};
    vt[8] = '{16'h5010, 0, 8'h00, 1, 2, 0, 0, 1, 0, 0, 1, 1};
    vt[9] = '{16'h5447, 0, 8'h02, 1, 0, 7, 1, 1, 0, 0, 1, 0};

    drive(16'h7C00, 0, 0, 1);
    drive(16'h7C00, 0, 0, 1);

    for (int n = 0; n < 10; n++) begin
      drive(vt[n].ins, vt[n].cond, 0, 0);
      chk("v_R_en", 16'(R_en), 16'(vt[n].r_en));
      chk("v_R0", 16'(R0_count), 16'(vt[n].r0));
      chk("v_s123", 16'({s1, s2, s3}), 16'({vt[n].a, vt[n].b, vt[n].e}));
      chk("v_s4", 16'(s4), 16'(vt[n].s4));
      chk("v_ramd", 16'({RAMd_en, RAMd_wren}), 16'({vt[n].ramd, vt[n].wren}));
      chk("v_rami", 16'(RAMi_en), 16'(vt[n].rami));
      chk("v_stk", 16'(stack_en), 16'(vt[n].stk));
    end

    // MUL with three EXEC2 cycles
    drive(16'h3940, 0, 0, 0);
    chk("mul_e1_rami", 16'(RAMi_en), 16'h0);
    chk("mul_e1_s3", 16'(s3), 16'd5);
    for (int n = 0; n < 3; n++) begin
      drive(16'h3940, 0, 0, 0);
      chk("mul_exec2", 16'(exec2), 16'h1);
      chk("mul_R_en", 16'(R_en), (n == 2) ? 16'h20 : 16'h0);
      chk("mul_rami", 16'(RAMi_en), (n == 2) ? 16'h1 : 16'h0);
    end
    drive(16'h7C00, 0, 0, 0);
    chk("mul_back", 16'(exec1), 16'h1);

    // LOAD into R2
    drive(16'h9005, 0, 0, 0);
    chk("ld_e1", 16'({RAMd_en, RAMd_wren, s4}), 16'b100);
    drive(16'h9005, 0, 0, 0);
    chk("ld_e2", 16'(R_en), 16'h04);

    // STP clears sp (sp=1 from the table PSH), then run restarts
    drive(16'h7E00, 0, 0, 0);
    chk("stp_e1", 16'({R0_count, RAMi_en}), 16'b00);
    drive(16'h7E00, 0, 0, 0);
    chk("stp_halt", 16'({halted, 4'(sp)}), 16'h10);
    drive(16'h7E00, 0, 1, 0);
    drive(16'h7C00, 0, 0, 0);
    chk("run_exec1", 16'(exec1), 16'h1);
    drive(16'h20CA, 0, 1, 0);

    // reset during the final MUL cycle suppresses the write
    drive(16'h3940, 0, 0, 0);
    drive(16'h3940, 0, 0, 0);
    drive(16'h3940, 0, 0, 0);
    drive(16'h3940, 0, 0, 1);
    chk("abort_R_en", 16'(R_en), 16'h0);
    drive(16'h7C00, 0, 0, 0);

`ifndef STACK_GUARD_EN
    drive(16'h5300, 0, 0, 0);
    chk("pop0_stk", 16'({stack_en, stack_rw}), 16'b11);
    drive(16'h5300, 0, 0, 0);
    chk("pop0_sp", 16'(sp), 16'd15);
    chk("pop0_R_en", 16'(R_en), 16'h10);
`else
    for (int n = 0; n < D; n++) begin
      drive(16'h5010, 0, 0, 0);
      chk("psh_s1", 16'(s1), 16'd2);
    end
    drive(16'h5010, 0, 0, 0);
    chk("full_sp", 16'(sp), 16'(D));
    chk("full_stk", 16'(stack_en), 16'h0);
    drive(16'h5010, 0, 1, 0);
    chk("fault", 16'(fault), 16'h1);
    drive(16'h5010, 0, 0, 0);
    chk("fault_sticky", 16'(fault), 16'h1);
    drive(16'h7C00, 0, 0, 1);
    chk("fault_clr", 16'({fault, 5'(sp)}), 16'h0);
`endif
    drive(16'h7C00, 0, 0, 1);

    cur = 16'h7C00;
    for (int n = 0; n < 3000; n++) begin
      if (m_ph == 3 || $urandom_range(0, 199) == 0) begin
        drive(cur, 0, 0, 1);
      end else begin
        if (m_ph != 1) cur = rand_instr();
        drive(cur, 1'($urandom_range(0, 1)),
              (m_ph == 2) ? ($urandom_range(0, 2) == 0)
                          : 1'($urandom_range(0, 1)), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_seq.md
Name: decode_seq

Overview:
- Parametrised successor to the CPU's combinational instruction decoder.
- Owns the EXEC1/EXEC2 execution phasing internally instead of taking phase inputs.
- Supports multi-cycle multiply (MUL_LAT), a tracked stack pointer with depth limits, and a HALT state with restart.
- Sits between the instruction RAM output register and the register file, ALU, data RAM and stack.

Parameters:
- MUL_LAT, 1: number of EXEC2 cycles for MUL/MLA/MLS (legal 1..15).
- STACK_DEPTH, 16: stack capacity in words (power of two, 2..256).
- SPW, 4: stack pointer width, equal to log2(STACK_DEPTH).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- instr  in  16  current instruction word; held stable while RAMi_en=0.
- COND_result  in  1  condition result for conditional jumps.
- run  in  1  one-cycle pulse to leave HALT.
- R_en  out  8  one-hot register write enables; bit n = Rn.
- R0_count  out  1  PC increment.
- s1, s2, s3  out  3 each  register-file read and write selects.
- s4  out  1  ALU/RAM result mux select.
- RAMd_wren, RAMd_en, RAMi_en, ALU_en  out  1 each  memory and ALU controls.
- stack_en, stack_rw  out  1 each  stack access strobe; rw: 1 = pop, 0 = push.
- sp  out  SPW  stack pointer (number of words held).
- exec1, exec2, halted, fault  out  1 each  state indicators.

Behaviour:
- Encoding:
  - instr[15]=1 selects LOAD/STORE: [14]=1 STORE, [13:11] Rls, [10:0] addr.
  - Otherwise op=[14:9], Rd=[8:6], Rs1=[5:3], Rs2=[2:0].
  - UJMP op=0000xx; JMP op=0001xx or 0010xx; MUL 011100, MLA 011101, MLS 011110; PSH 101000; POP 101001; NOP 111110; STP 111111.
  - All other ops are single-cycle ALU ops.
- States: S_EXEC1, S_EXEC2, S_HALT, S_FAULT.
- Reset: while RST is high, state=S_EXEC1, sp=0, EXEC2 counter=0, and every output is 0 except exec1=1.
- S_EXEC1 (one cycle), outputs:
  - R0_count=1 unless UJMP/JMP/STP.
  - ALU ops assert R_en[Rd]; UJMP, and JMP with COND_result=1, assert R_en[0]. None for STORE/LOAD/MUL/MLA/MLS/POP/NOP/STP.
  - s1=Rs1 for ALU/MUL/MLA/MLS/PSH ops; s1=Rls for STORE.
  - s2=Rs2 and s3=Rd for ALU/MUL/MLA/MLS ops; otherwise s1/s2/s3=0.
  - s4 = ~(LOAD|STORE).
  - RAMd_en = LOAD|STORE; RAMd_wren = STORE; ALU_en = LOAD|STORE.
  - RAMi_en=1 only for ops that complete in this cycle, excluding STP.
- S_EXEC1 transitions:
  - LOAD/POP/MUL/MLA/MLS go to S_EXEC2 with counter=0.
  - STP goes to S_HALT and sets sp to 0.
  - All other ops stay in S_EXEC1.
- S_EXEC2:
  - Counter increments each cycle.
  - Last cycle: counter = 0 for LOAD/POP, counter = MUL_LAT-1 for multiply ops.
  - Only on the last cycle: R_en[Rls] for LOAD, R_en[Rd] otherwise; RAMi_en=1; then go to S_EXEC1.
  - Non-final cycles: all enables 0, exec2=1.
- Stack:
  - PSH in EXEC1: stack_en=1, stack_rw=0, sp+1 at the clock edge.
  - POP in EXEC1: stack_en=1, stack_rw=1, sp-1 at the edge; data is written to Rd in EXEC2.
- S_HALT: halted=1, all enables 0; run=1 goes to S_EXEC1 on the next edge. run is ignored in every other state.
- S_FAULT: fault=1, halted=1, all enables 0; leaves only via RST.
- RST asserted mid-EXEC2 aborts the instruction with no register write.

Optional Feature:
- STACK_GUARD_EN defined:
  - PSH with sp=STACK_DEPTH, or POP with sp=0, suppresses stack_en, R0_count and any write, and goes to S_FAULT.
  - A PSH at sp=STACK_DEPTH-1 is legal.
- Not defined:
  - sp wraps modulo STACK_DEPTH, with no fault detection.
  - fault is tied to 0.
  - S_FAULT is unreachable.

Test Plan:
- instr=0x20CA in EXEC1 -> R_en=8'b00001000, s1=1, s2=2, s3=3, s4=1, R0_count=1, RAMi_en=1, state stays S_EXEC1.
- MUL_LAT=3, instr=0x3940 -> one EXEC1 cycle, then three exec2 cycles; R_en=8'b00100000 and RAMi_en=1 only on the third; next cycle exec1=1.
- instr=0x9005 -> EXEC1: RAMd_en=1, RAMd_wren=0, s4=0; EXEC2: R_en[2]=1. Then instr=0xD005 -> RAMd_wren=1, s1=2, no R_en.
- STACK_GUARD_EN, STACK_DEPTH=4: four PSH (0x5010) -> sp=4, s1=2 each time; fifth PSH -> stack_en=0, fault=1; run pulse is ignored; RST -> sp=0, fault=0.
- Without STACK_GUARD_EN: POP (0x5300) at sp=0 -> stack_en=1, stack_rw=1, sp=15; EXEC2 gives R_en[4]=1.
- instr=0x7E00 -> R0_count=0, RAMi_en=0, halted=1 with sp=0; run pulse -> exec1=1 on the next cycle.
